// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit.
//   cond_t  : 4-bit instruction condition field encodings
//   flags_t : flag register layout {N,Z,C,V}
//   FLAG_*  : bit positions of each flag within flags_t
package cond_pkg;

  typedef logic [3:0] flags_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111   // reserved: never executes
  } cond_t;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator.
//   Cond   in  4 : instruction condition field
//   Flags  in  4 : flag values {N,Z,C,V} to test against
//   CondEx out 1 : 1 when the condition holds
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  flags_t     Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  always_comb begin
    n = Flags[FLAG_N];
    z = Flags[FLAG_Z];
    c = Flags[FLAG_C];
    v = Flags[FLAG_V];
    CondEx = 1'b0;
    case (cond_t'(Cond))
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ~(n ^ v);
      COND_LT: CondEx = n ^ v;
      COND_GT: CondEx = ~z & ~(n ^ v);
      COND_LE: CondEx = z | (n ^ v);
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage conditional-execution unit.
// Holds the architectural NZCV flags, evaluates the condition field against
// the stored (pre-update) flags and gates the decoder controls. Gated
// controls are output directly (E) and through a one-cycle register (M).
//   clk, reset                  : clock, synchronous active-high reset
//   valid_i, stall_i, flush_i   : instruction present / hold / kill
//   Cond, ALUFlags, FlagW       : condition field, new flags, flag write enables
//   PCS, RegW, MemW             : ungated controls
//   CondEx                      : condition result against stored flags
//   PCSrcE, RegWriteE, MemWriteE: gated controls, combinational
//   PCSrcM, RegWriteM, MemWriteM: gated controls, registered
//   Flags                       : flag register {N,Z,C,V}
module cond_unit
  import cond_pkg::*;
#(
  parameter flags_t FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_i,
  input  logic       stall_i,
  input  logic       flush_i,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  output logic       CondEx,
  output logic       PCSrcE,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       PCSrcM,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic [3:0] Flags
);

  logic [1:0] nz_q;
  logic [1:0] cv_q;
  logic       go;

  assign Flags = {nz_q, cv_q};

  cond_check u_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (CondEx)
  );

  // Flush dominates stall; either one suppresses all effects.
  assign go        = valid_i & CondEx & ~stall_i & ~flush_i;
  assign PCSrcE    = PCS  & go;
  assign RegWriteE = RegW & go;
  assign MemWriteE = MemW & go;

  always_ff @(posedge clk) begin
    if (reset) begin
      nz_q      <= FLAG_RESET[3:2];
      cv_q      <= FLAG_RESET[1:0];
      PCSrcM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
    end else begin
      if (go & FlagW[1]) nz_q <= ALUFlags[3:2];
      if (go & FlagW[0]) cv_q <= ALUFlags[1:0];
      PCSrcM    <= PCSrcE;
      RegWriteM <= RegWriteE;
      MemWriteM <= MemWriteE;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset, valid_i, stall_i, flush_i;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW;
  logic       CondEx, PCSrcE, RegWriteE, MemWriteE;
  logic       PCSrcM, RegWriteM, MemWriteM;
  logic [3:0] Flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cond_unit #(.FLAG_RESET(4'b0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_i   (valid_i),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .Cond      (Cond),
    .ALUFlags  (ALUFlags),
    .FlagW     (FlagW),
    .PCS       (PCS),
    .RegW      (RegW),
    .MemW      (MemW),
    .CondEx    (CondEx),
    .PCSrcE    (PCSrcE),
    .RegWriteE (RegWriteE),
    .MemWriteE (MemWriteE),
    .PCSrcM    (PCSrcM),
    .RegWriteM (RegWriteM),
    .MemWriteM (MemWriteM),
    .Flags     (Flags)
  );

  // Reference condition table, written directly from the code list.
  function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  // Advance one edge; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    Cond = 4'd0; ALUFlags = 4'd0; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;

    // Reset
    tick();
    reset = 1'b0;
    chk("rst_flags", Flags, 4'b0000);
    chk("rst_m", {1'b0, PCSrcM, RegWriteM, MemWriteM}, 4'b0000);
    valid_i = 1'b1; Cond = 4'b0000;
    #1 chk("rst_eq", {3'b0, CondEx}, 4'd0);
    Cond = 4'b1110;
    #1 chk("rst_al", {3'b0, CondEx}, 4'd1);

    // Flag write then conditional skip
    FlagW = 2'b11; ALUFlags = 4'b0100;
    tick();
    chk("fw_flags", Flags, 4'b0100);
    FlagW = 2'b00; Cond = 4'b0000; RegW = 1'b1;
    #1 chk("eq_regwe", {3'b0, RegWriteE}, 4'd1);
    tick();
    chk("eq_regwm", {3'b0, RegWriteM}, 4'd1);
    Cond = 4'b0001;
    #1 chk("ne_regwe", {3'b0, RegWriteE}, 4'd0);
    tick();
    chk("ne_regwm", {3'b0, RegWriteM}, 4'd0);
    valid_i = 1'b0; RegW = 1'b0;

    // Partial write: only C,V
    do_reset();
    valid_i = 1'b1; Cond = 4'b1110; FlagW = 2'b01; ALUFlags = 4'b1111;
    tick();
    chk("pw_flags", Flags, 4'b0011);
    FlagW = 2'b00; Cond = 4'b1010;
    #1 chk("pw_ge", {3'b0, CondEx}, 4'd0);
    Cond = 4'b1011;
    #1 chk("pw_lt", {3'b0, CondEx}, 4'd1);
    valid_i = 1'b0;

    // Failed condition blocks flag write
    do_reset();
    valid_i = 1'b1; Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1000; MemW = 1'b1;
    #1 chk("fc_memwe", {3'b0, MemWriteE}, 4'd0);
    tick();
    chk("fc_flags", Flags, 4'b0000);
    chk("fc_memwm", {3'b0, MemWriteM}, 4'd0);
    MemW = 1'b0;

    // Stall for 2 cycles
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1001; RegW = 1'b1; stall_i = 1'b1;
    #1 chk("st_regwe", {3'b0, RegWriteE}, 4'd0);
    tick();
    chk("st1_flags", Flags, 4'b0000);
    chk("st1_m", {1'b0, PCSrcM, RegWriteM, MemWriteM}, 4'b0000);
    tick();
    chk("st2_flags", Flags, 4'b0000);
    chk("st2_m", {1'b0, PCSrcM, RegWriteM, MemWriteM}, 4'b0000);
    stall_i = 1'b0;
    #1 chk("rel_regwe", {3'b0, RegWriteE}, 4'd1);
    tick();
    chk("rel_flags", Flags, 4'b1001);
    chk("rel_regwm", {3'b0, RegWriteM}, 4'd1);
    valid_i = 1'b0; RegW = 1'b0; ALUFlags = 4'b0110;
    tick();
    chk("rel_once", Flags, 4'b1001);
    chk("rel_bubble", {3'b0, RegWriteM}, 4'd0);

    // Flush together with stall, then plain execution
    valid_i = 1'b1; PCS = 1'b1; flush_i = 1'b1; stall_i = 1'b1;
    #1 chk("fl_pcse", {3'b0, PCSrcE}, 4'd0);
    tick();
    chk("fl_pcsm", {3'b0, PCSrcM}, 4'd0);
    chk("fl_flags", Flags, 4'b1001);
    flush_i = 1'b0; stall_i = 1'b0;
    #1 chk("nf_pcse", {3'b0, PCSrcE}, 4'd1);
    tick();
    chk("nf_pcsm", {3'b0, PCSrcM}, 4'd1);
    chk("nf_flags", Flags, 4'b0110);

    // Reset mid-stream overrides an executing instruction
    ALUFlags = 4'b1111; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_flags", Flags, 4'b0000);
    chk("mr_pcsm", {3'b0, PCSrcM}, 4'd0);
    PCS = 1'b0; valid_i = 1'b0;

    // Exhaustive sweep: preload every flag value, test every condition
    for (int unsigned f = 0; f < 16; f++) begin
      valid_i = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'(f);
      tick();
      valid_i = 1'b0; FlagW = 2'b00;
      chk("sw_flags", Flags, 4'(f));
      for (int unsigned c = 0; c < 16; c++) begin
        Cond = 4'(c);
        #1 chk($sformatf("sw_c%0d_f%0d", c, f), {3'b0, CondEx},
               {3'b0, exp_cond(4'(c), 4'(f))});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
# cond_unit

Execute-stage conditional-execution unit placed directly downstream of the 32-bit ALU. It consumes the ALU's NZCV flags, holds the architectural flag register, evaluates the instruction's 4-bit condition field against the stored flags, and gates the control signals (`RegW`, `MemW`, `PCS`). Gated controls go to the datapath both immediately and through a one-cycle Memory-stage pipeline register. Stall and flush inputs let the hazard unit hold the flag state or kill the instruction.

## Interface
Parameters:
- `FLAG_RESET`, default `4'b0000`: value loaded into the flag register on reset, ordered {N,Z,C,V}.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `valid_i` in 1: an instruction occupies Execute this cycle.
- `stall_i` in 1: Execute is held; no architectural update this cycle.
- `flush_i` in 1: the Execute instruction is killed.
- `Cond` in 4: condition field.
- `ALUFlags` in 4: {N,Z,C,V} from the ALU for the current instruction.
- `FlagW` in 2: bit1 allows an N,Z update; bit0 allows a C,V update.
- `PCS`, `RegW`, `MemW` in 1 each: ungated decoder controls.
- `CondEx` out 1: condition result against the stored flags.
- `PCSrcE`, `RegWriteE`, `MemWriteE` out 1 each: gated controls (combinational).
- `PCSrcM`, `RegWriteM`, `MemWriteM` out 1 each: gated controls, registered.
- `Flags` out 4: current flag register contents {N,Z,C,V}.

## Operation
- `CondEx` is evaluated against `Flags` (the pre-update value), never against `ALUFlags`. There is no bypass.
- Condition codes:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (reserved, never executes)
- Define `go` = `valid_i & CondEx & !stall_i & !flush_i`.
- Gated controls: `PCSrcE` = `PCS & go`, `RegWriteE` = `RegW & go`, `MemWriteE` = `MemW & go`.
- Flag update at the clock edge:
  - If `go & FlagW[1]`, N,Z load from `ALUFlags[3:2]`.
  - If `go & FlagW[0]`, C,V load from `ALUFlags[1:0]`.
  - Otherwise each half holds.
  - The two halves are independent.
- The M register loads {PCSrcE,RegWriteE,MemWriteE} every non-reset cycle. During a stall or flush it therefore loads a bubble (000).
- `reset` takes priority over every other input.

## Timing
- Reset values:
  - `Flags` = `FLAG_RESET`.
  - `PCSrcM`, `RegWriteM`, `MemWriteM` = 0.
  - Combinational outputs follow from those values.
- Latency:
  - `*E` outputs and `CondEx`: 0 cycles.
  - `*M` outputs: 1 cycle.
  - `Flags`: visible to the next instruction's `CondEx` 1 cycle after the producing instruction.
- Back-to-back instructions: the second instruction sees the first instruction's flags.
- Stall held N cycles: flags are frozen and `*M` = 0 for N cycles. After the stall releases, the held instruction updates flags exactly once.
- Simultaneous `stall_i` and `flush_i`: treated as flush. No update, bubble.
- Reset asserted mid-stream: the next edge restores reset values regardless of `valid_i`/`go`.

## Structure
- Shared package `cond_pkg`:
  - enum `cond_t` holding the 16 codes.
  - localparams `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`.
  - typedef `flags_t` (logic [3:0]).
- Sub-module `cond_check`: purely combinational, (`Cond`, `Flags`) -> `CondEx`. It can be reused by a future branch-prediction check.
- The top level holds the two flag half-registers, the gating logic and the M pipeline register.

## Test plan
- Reset:
  - Stimulus: `reset`=1 for one edge, then 0.
  - Response: `Flags`=0000, all `*M`=0. `Cond`=0000 with `valid_i`=1 gives `CondEx`=0. `Cond`=1110 gives 1.
- Flag write and conditional skip:
  - Stimulus: AL instruction, `FlagW`=11, `ALUFlags`=0100. Next cycle EQ with `RegW`=1. Then NE with `RegW`=1.
  - Response: `Flags`=0100. EQ gives `RegWriteE`=1, then `RegWriteM`=1 one cycle later. NE gives `RegWriteE`=0.
- Partial write:
  - Stimulus: `Flags`=0000, `FlagW`=01, `ALUFlags`=1111.
  - Response: `Flags`=0011. A following GE gives 0 (N=0, V=1). LT gives 1.
- Failed condition blocks flag write:
  - Stimulus: `Flags`=0000, EQ with `FlagW`=11, `ALUFlags`=1000.
  - Response: `Flags` stays 0000, `MemWriteE`=0.
- Stall/flush:
  - Stimulus: AL instruction, `FlagW`=11, `ALUFlags`=1001, with `stall_i`=1 for 2 cycles, then 0. A separate case asserts `flush_i`=1 with `PCS`=1.
  - Response: during the stall `Flags` is unchanged and `*M`=000. After release `Flags`=1001, loaded once. The flush gives `PCSrcE`=0, `PCSrcM`=0, `Flags` unchanged.
- Exhaustive condition sweep:
  - Stimulus: all 16 `Cond` values × 16 preloaded flag values.
  - Response: `CondEx` matches the condition-code list above. 1111 is always 0.
